// File: rtl/img_metadata_header_parser.sv
// Receive-side metadata header parser: gathers four 12-bit dozens after an image,
// rebuilds the 48-bit metadata word and presents it over a valid/ack handshake.
module img_metadata_header_parser #(
  parameter int GAP_MAX = 15,
  parameter int GAP_W   = 8
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic        header_start,
  input  logic [11:0] dozen_in,
  input  logic        dozen_in_valid,
  input  logic        meta_ack,
  output logic [1:0]  compression,
  output logic        rgb,
  output logic        cam_id,
  output logic [27:0] timestamp,
  output logic [15:0] trigger_index,
  output logic        meta_valid,
  output logic        hdr_timeout,
  output logic        hdr_overrun,
  output logic        stray_dozen
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);

  logic [0:0]       state;
  logic [2:0]       count;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_inc;
  logic [35:0]      shift;
  logic [47:0]      meta;

  assign gap_inc = gap + 1'b1;

  assign compression   = meta[47:46];
  assign rgb           = meta[45];
  assign cam_id        = meta[44];
  assign timestamp     = meta[43:16];
  assign trigger_index = meta[15:0];

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 3'd0;
      gap         <= '0;
      shift       <= '0;
      meta        <= '0;
      meta_valid  <= 1'b0;
      hdr_timeout <= 1'b0;
      hdr_overrun <= 1'b0;
      stray_dozen <= 1'b0;
    end else begin
      hdr_timeout <= 1'b0;
      hdr_overrun <= 1'b0;
      stray_dozen <= 1'b0;
      if (meta_valid && meta_ack) begin
        meta_valid <= 1'b0;
      end

      // header_start always (re)opens a header; a dozen in the same cycle is dozen 0
      if (header_start) begin
        state <= COLLECT;
        gap   <= '0;
        count <= dozen_in_valid ? 3'd1 : 3'd0;
        shift <= dozen_in_valid ? {24'd0, dozen_in} : 36'd0;
      end else if (state == IDLE) begin
        if (dozen_in_valid) begin
          stray_dozen <= 1'b1;
        end
      end else if (dozen_in_valid) begin
        gap <= '0;
        if (count == 3'd3) begin
          state       <= IDLE;
          count       <= 3'd0;
          shift       <= '0;
          meta        <= {shift, dozen_in};
          meta_valid  <= 1'b1;
          // an ack landing on the publish cycle retires the old word cleanly
          hdr_overrun <= meta_valid && !meta_ack;
        end else begin
          count <= count + 3'd1;
          shift <= {shift[23:0], dozen_in};
        end
      end else if (gap_inc == GAP_LIMIT) begin
        hdr_timeout <= 1'b1;
        state       <= IDLE;
        gap         <= GAP_LIMIT;
        count       <= 3'd0;
        shift       <= '0;
      end else begin
        gap <= gap_inc;
      end
    end
  end

endmodule

// File: tb/tb_img_metadata_header_parser.sv
// Directed bench for img_metadata_header_parser: a vector table of whole headers
// plus hand-written gap, timeout, overrun, stray, restart and reset sequences.
module tb_img_metadata_header_parser;

  logic        sysClk = 1'b0;
  logic        reset = 1'b1;
  logic        header_start = 1'b0;
  logic [11:0] dozen_in = 12'd0;
  logic        dozen_in_valid = 1'b0;
  logic        meta_ack = 1'b0;
  logic [1:0]  compression;
  logic        rgb;
  logic        cam_id;
  logic [27:0] timestamp;
  logic [15:0] trigger_index;
  logic        meta_valid;
  logic        hdr_timeout;
  logic        hdr_overrun;
  logic        stray_dozen;

  int checks = 0;
  int failures = 0;
  int n_to = 0;
  int n_ovr = 0;
  int n_stray = 0;

  img_metadata_header_parser #(.GAP_MAX(15), .GAP_W(8)) dut (
    .sysClk(sysClk), .reset(reset), .header_start(header_start),
    .dozen_in(dozen_in), .dozen_in_valid(dozen_in_valid), .meta_ack(meta_ack),
    .compression(compression), .rgb(rgb), .cam_id(cam_id), .timestamp(timestamp),
    .trigger_index(trigger_index), .meta_valid(meta_valid), .hdr_timeout(hdr_timeout),
    .hdr_overrun(hdr_overrun), .stray_dozen(stray_dozen)
  );

  always #5 sysClk = ~sysClk;

  always @(negedge sysClk) begin
    if (!reset) begin
      n_to    += int'(hdr_timeout);
      n_ovr   += int'(hdr_overrun);
      n_stray += int'(stray_dozen);
    end
  end

  typedef struct {
    logic [47:0] w;
    logic        same;
    logic [1:0]  comp;
    logic        rgb;
    logic        cam;
    logic [27:0] ts;
    logic [15:0] trig;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_fields(input string nm, input vec_t v);
    chk({nm, ".compression"}, 48'(compression), 48'(v.comp));
    chk({nm, ".rgb"}, 48'(rgb), 48'(v.rgb));
    chk({nm, ".cam_id"}, 48'(cam_id), 48'(v.cam));
    chk({nm, ".timestamp"}, 48'(timestamp), 48'(v.ts));
    chk({nm, ".trigger_index"}, 48'(trigger_index), 48'(v.trig));
    chk({nm, ".meta_valid"}, 48'(meta_valid), 48'd1);
  endtask

  // Drives header_start then the four dozens back to back; returns just after the
  // edge that sampled the last dozen, where the published word should be visible.
  task automatic send_hdr(input logic [47:0] w, input logic same, input logic ack_last);
    logic [11:0] d;
    header_start   = 1'b1;
    dozen_in_valid = same;
    dozen_in       = w[47:36];
    tick();
    header_start = 1'b0;
    for (int k = (same ? 1 : 0); k < 4; k++) begin
      d = w[47 - 12*k -: 12];
      dozen_in_valid = 1'b1;
      dozen_in       = d;
      meta_ack       = (k == 3) && ack_last;
      tick();
    end
    dozen_in_valid = 1'b0;
    meta_ack       = 1'b0;
  endtask

  initial begin
    int ovr0;
    int to0;
    int st0;
    vecs[0] = '{48'h8A123456789A, 1'b0, 2'b10, 1'b0, 1'b0, 28'hA123456, 16'h789A};
    vecs[1] = '{48'hFFFFFFFFFFFF, 1'b1, 2'b11, 1'b1, 1'b1, 28'hFFFFFFF, 16'hFFFF};
    vecs[2] = '{48'h5ABCDEF01234, 1'b0, 2'b01, 1'b0, 1'b1, 28'hABCDEF0, 16'h1234};
    vecs[3] = '{48'h300000000001, 1'b1, 2'b00, 1'b1, 1'b1, 28'h0000000, 16'h0001};
    vecs[4] = '{48'h000000000001, 1'b0, 2'b00, 1'b0, 1'b0, 28'h0000000, 16'h0001};

    #3;
    chk("reset.fields", {compression, rgb, cam_id, timestamp, trigger_index}, 48'd0);
    chk("reset.flags", 48'({meta_valid, hdr_timeout, hdr_overrun, stray_dozen}), 48'd0);
    tick();
    reset = 1'b0;
    tick();

    // Table: each header published, held while unacked, dropped after ack
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("vec%0d.pre_valid", i), 48'(meta_valid), 48'd0);
      send_hdr(vecs[i].w, vecs[i].same, 1'b0);
      $display("txn vec%0d word=%012h same=%0b", i, vecs[i].w, vecs[i].same);
      check_fields($sformatf("vec%0d", i), vecs[i]);
      chk($sformatf("vec%0d.overrun", i), 48'(hdr_overrun), 48'd0);
      tick();
      tick();
      check_fields($sformatf("vec%0d.hold", i), vecs[i]);
      meta_ack = 1'b1;
      tick();
      meta_ack = 1'b0;
      chk($sformatf("vec%0d.after_ack", i), 48'(meta_valid), 48'd0);
      tick();
    end

    // Gapped header: 14 idle cycles between dozens is still legal
    to0 = n_to;
    header_start = 1'b1;
    tick();
    header_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dozen_in_valid = 1'b1;
      dozen_in = vecs[2].w[47 - 12*k -: 12];
      tick();
      dozen_in_valid = 1'b0;
      if (k < 3) repeat (14) tick();
    end
    $display("txn gapped14 word=%012h", vecs[2].w);
    check_fields("gapped", vecs[2]);
    chk("gapped.no_timeout", 48'(n_to - to0), 48'd0);
    meta_ack = 1'b1;
    tick();
    meta_ack = 1'b0;
    tick();

    // Timeout: two dozens then 15 idle cycles
    header_start = 1'b1;
    tick();
    header_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dozen_in_valid = 1'b1;
      dozen_in = 12'hABC;
      tick();
    end
    dozen_in_valid = 1'b0;
    repeat (14) tick();
    chk("timeout.early", 48'(hdr_timeout), 48'd0);
    tick();
    $display("txn timeout after 15 idle cycles");
    chk("timeout.pulse", 48'(hdr_timeout), 48'd1);
    tick();
    chk("timeout.width", 48'(hdr_timeout), 48'd0);
    chk("timeout.meta_valid", 48'(meta_valid), 48'd0);
    chk("timeout.count", 48'(n_to - to0), 48'd1);
    send_hdr(vecs[0].w, 1'b0, 1'b0);
    $display("txn post_timeout word=%012h", vecs[0].w);
    check_fields("post_timeout", vecs[0]);

    // Overrun: vec0 still unacked, vec4 published back to back
    ovr0 = n_ovr;
    send_hdr(vecs[4].w, 1'b0, 1'b0);
    $display("txn overrun word=%012h", vecs[4].w);
    check_fields("overrun", vecs[4]);
    chk("overrun.pulse", 48'(hdr_overrun), 48'd1);
    tick();
    chk("overrun.width", 48'(hdr_overrun), 48'd0);
    chk("overrun.valid_held", 48'(meta_valid), 48'd1);
    send_hdr(vecs[1].w, vecs[1].same, 1'b1);
    $display("txn ack_on_publish word=%012h", vecs[1].w);
    check_fields("ack_on_publish", vecs[1]);
    chk("ack_on_publish.no_overrun", 48'(hdr_overrun), 48'd0);
    chk("overrun.count", 48'(n_ovr - ovr0), 48'd1);
    meta_ack = 1'b1;
    tick();
    meta_ack = 1'b0;
    chk("ack_on_publish.dropped", 48'(meta_valid), 48'd0);

    // Stray dozen in IDLE
    st0 = n_stray;
    dozen_in_valid = 1'b1;
    dozen_in = 12'h123;
    tick();
    dozen_in_valid = 1'b0;
    $display("txn stray dozen");
    chk("stray.pulse", 48'(stray_dozen), 48'd1);
    tick();
    chk("stray.width", 48'(stray_dozen), 48'd0);
    chk("stray.meta_valid", 48'(meta_valid), 48'd0);

    // Restart after two dozens: only the new header is published
    to0 = n_to;
    ovr0 = n_ovr;
    header_start = 1'b1;
    tick();
    header_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dozen_in_valid = 1'b1;
      dozen_in = 12'h111 * 12'(k + 1);
      tick();
    end
    dozen_in_valid = 1'b0;
    send_hdr(vecs[2].w, 1'b0, 1'b0);
    $display("txn restart word=%012h", vecs[2].w);
    check_fields("restart", vecs[2]);
    chk("restart.no_errors", 48'((n_to - to0) + (n_ovr - ovr0) + (n_stray - st0 - 1)), 48'd0);
    meta_ack = 1'b1;
    tick();
    meta_ack = 1'b0;

    // Async reset mid-header with a published word outstanding
    send_hdr(vecs[1].w, vecs[1].same, 1'b0);
    header_start = 1'b1;
    tick();
    header_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dozen_in_valid = 1'b1;
      dozen_in = 12'hFFF;
      tick();
    end
    dozen_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("txn async reset mid-header");
    chk("midreset.fields", {compression, rgb, cam_id, timestamp, trigger_index}, 48'd0);
    chk("midreset.meta_valid", 48'(meta_valid), 48'd0);
    #2 reset = 1'b0;
    tick();
    send_hdr(vecs[0].w, 1'b0, 1'b0);
    $display("txn post_reset word=%012h", vecs[0].w);
    check_fields("post_reset", vecs[0]);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
